// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and constants for the shift sequencer slice.
//   op_t    : command opcodes carried on cmd_op
//   state_t : sequencer FSM states
//   S_*     : mode-select codes driven on s toward the universal shift register
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROTR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

endpackage

// File: rtl/shift_step_counter.sv
// shift_step_counter: loadable down counter for the number of remaining
// shift steps.
//   clk      in  clock
//   clr      in  asynchronous active-low reset
//   load     in  load load_val into the counter (wins over dec)
//   load_val in  CNT_W step count
//   dec      in  decrement by one (saturates at zero)
//   count    out current remaining steps
//   last     out high when count == 1, i.e. this is the final step
module shift_step_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign last = (count == ONE);

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: turns one accepted command (LOAD / SHR / SHL / ROTR by N)
// into the per-cycle s/i/sr/sl drive of a universal shift register whose
// output is fed back on q.
//   clk        in  clock
//   clr        in  asynchronous active-low reset
//   cmd_valid  in  command present
//   cmd_ready  out command can be accepted (state == IDLE)
//   cmd_op     in  opcode (op_t)
//   cmd_data   in  LOAD word
//   cmd_fill   in  serial fill bit for SHR/SHL
//   cmd_count  in  number of shift steps
//   q          in  current register contents
//   s          out register mode select
//   i          out register parallel-load data
//   sr, sl     out register serial inputs
//   busy       out high whenever not IDLE
//   done       out one-cycle completion pulse
//   state_dbg  out current FSM state, for observation only
//
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high; op/data/fill/count are captured at that edge.
// While cmd_ready is low cmd_valid is ignored and nothing is queued, so the
// master must hold the command until it is taken.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] q,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] i,
  output logic             sr,
  output logic             sl,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  state_t           state;
  op_t              op_in;
  logic             accept;
  logic             cnt_load;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt_value;
  logic             rot_r;
  logic             sr_r;

  assign op_in    = op_t'(cmd_op);
  assign accept   = cmd_valid && (state == IDLE);
  assign cnt_load = accept && (op_in != OP_LOAD) && (cmd_count != '0);

  shift_step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (cmd_count),
    .dec      (state == SHIFT),
    .count    (cnt_value),
    .last     (cnt_last)
  );

  // Outputs are registered alongside the state transition, so each one is
  // already valid for the whole cycle spent in the new state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      s     <= S_HOLD;
      i     <= '0;
      sr_r  <= 1'b0;
      sl    <= 1'b0;
      rot_r <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (op_in == OP_LOAD) begin
              state <= LOAD;
              s     <= S_LOAD;
              i     <= cmd_data;
            end else if (cmd_count == '0) begin
              // Nothing to move: report completion straight away.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
              s     <= (op_in == OP_SHL) ? S_SHL : S_SHR;
              sr_r  <= (op_in == OP_SHR) ? cmd_fill : 1'b0;
              sl    <= (op_in == OP_SHL) ? cmd_fill : 1'b0;
              rot_r <= (op_in == OP_ROTR);
            end
          end
        end
        LOAD: begin
          state <= DONE;
          s     <= S_HOLD;
          i     <= '0;
          done  <= 1'b1;
        end
        SHIFT: begin
          if (cnt_last) begin
            state <= DONE;
            s     <= S_HOLD;
            sr_r  <= 1'b0;
            sl    <= 1'b0;
            rot_r <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          s     <= S_HOLD;
          i     <= '0;
          sr_r  <= 1'b0;
          sl    <= 1'b0;
          rot_r <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Rotate feeds the register's LSB back into its MSB; this is the only
  // output path that depends combinationally on q.
  assign sr        = rot_r ? q[0] : sr_r;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
